param_stream_loader: RTL

PARAM_STREAM_LOADER -- requirements
Module: param_stream_loader

---
 rtl/param_stream_loader_if.sv | 28 ++
 rtl/param_stream_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/param_stream_loader_if.sv
// Byte-stream input and element-write output bundle
// for the parameter stream loader.
interface param_stream_loader_if #(
    parameter int ADDR_W = 15
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              wr_en;
    logic [1:0]        wr_seg;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        output rx_data, rx_valid,
        input  wr_en, wr_seg, wr_addr, wr_data,
        input  busy, done, err, err_code
    );

    modport slave (
        input  rx_data, rx_valid,
        output wr_en, wr_seg, wr_addr, wr_data,
        output busy, done, err, err_code
    );
endinterface

// File: rtl/param_stream_loader.sv
// Loads a marker-framed byte stream into up to four parameter
// segments of narrow or wide elements, then verifies an XOR checksum.
module param_stream_loader #(
    parameter int unsigned SEG_LEN0 = 36,
    parameter int unsigned SEG_LEN1 = 4,
    parameter int unsigned SEG_LEN2 = 27040,
    parameter int unsigned SEG_LEN3 = 10,
    parameter logic [3:0]  SEG_WIDE = 4'b1010,
    parameter logic [7:0]  MARKER   = 8'h55,
    parameter int unsigned TIMEOUT  = 1000000,
    parameter int          ADDR_W   = 15
) (
    input logic            clk,
    input logic            rst,
    param_stream_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam int unsigned SEG_LEN [4] =
        '{SEG_LEN0, SEG_LEN1, SEG_LEN2, SEG_LEN3};
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    // {found, index} of the first nonzero segment at or after 'from'
    function automatic logic [2:0] seek(input int from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (i >= from && SEG_LEN[i] != 0) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        seg_q, seg_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        byte_q, byte_d;
    logic [23:0]       acc_q, acc_d;
    logic [7:0]        csum_q, csum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              wr_en_q, wr_en_d;
    logic [1:0]        wr_seg_q, wr_seg_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic       rx_vld;
    logic       is_marker;
    logic       wide;
    logic       elem_done;
    logic       last_elem;
    logic       tmo_hit;
    logic       start;
    logic       active;
    logic [2:0] first;
    logic [2:0] nxt;

    always_comb begin
        rx_vld    = bus.rx_valid;
        is_marker = rx_vld && (bus.rx_data == MARKER);
        wide      = SEG_WIDE[seg_q];
        active    = (state_q == S_LOAD) || (state_q == S_CHECK);
        start     = !active && is_marker;
        elem_done = (state_q == S_LOAD) && rx_vld
                    && (!wide || byte_q == 2'd3);
        last_elem = (32'(idx_q) + 32'd1) == SEG_LEN[seg_q];
        tmo_hit   = active && !rx_vld
                    && (tmo_q == TMO_W'(TIMEOUT - 1));
        first     = seek(0);
        nxt       = seek(int'(seg_q) + 1);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (is_marker) state_d = first[2] ? S_LOAD : S_CHECK;
            end
            S_LOAD: begin
                if (tmo_hit)
                    state_d = S_ERROR;
                else if (elem_done && last_elem && !nxt[2])
                    state_d = S_CHECK;
            end
            S_CHECK: begin
                if (tmo_hit)
                    state_d = S_ERROR;
                else if (rx_vld)
                    state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        seg_d      = seg_q;
        idx_d      = idx_q;
        byte_d     = byte_q;
        acc_d      = acc_q;
        csum_d     = csum_q;
        tmo_d      = tmo_q;
        wr_en_d    = 1'b0;
        wr_seg_d   = wr_seg_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        if (start) begin
            seg_d      = first[1:0];
            idx_d      = '0;
            byte_d     = '0;
            acc_d      = '0;
            csum_d     = '0;
            tmo_d      = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
            err_code_d = 2'd0;
        end else if (active) begin
            tmo_d = rx_vld ? '0 : tmo_q + 1'b1;
            if (tmo_hit) begin
                tmo_d      = '0;
                byte_d     = '0;
                acc_d      = '0;
                err_d      = 1'b1;
                err_code_d = 2'd1;
            end else if (rx_vld && state_q == S_LOAD) begin
                csum_d = csum_q ^ bus.rx_data;
                unique case (byte_q)
                    2'd0:    acc_d[7:0]   = bus.rx_data;
                    2'd1:    acc_d[15:8]  = bus.rx_data;
                    2'd2:    acc_d[23:16] = bus.rx_data;
                    default: ;
                endcase
                if (elem_done) begin
                    wr_en_d   = 1'b1;
                    wr_seg_d  = seg_q;
                    wr_addr_d = idx_q;
                    wr_data_d = wide ? {bus.rx_data, acc_q}
                                     : {{24{bus.rx_data[7]}}, bus.rx_data};
                    byte_d    = '0;
                    if (last_elem) begin
                        idx_d = '0;
                        if (nxt[2]) seg_d = nxt[1:0];
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    byte_d = byte_q + 1'b1;
                end
            end else if (rx_vld) begin
                // checksum byte: compared only, never written
                if (bus.rx_data == csum_q) begin
                    done_d = 1'b1;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= '0;
            idx_q      <= '0;
            byte_q     <= '0;
            acc_q      <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_seg_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            seg_q      <= seg_d;
            idx_q      <= idx_d;
            byte_q     <= byte_d;
            acc_q      <= acc_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
            wr_en_q    <= wr_en_d;
            wr_seg_q   <= wr_seg_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        bus.busy     = (state_q == S_LOAD) || (state_q == S_CHECK);
        bus.wr_en    = wr_en_q;
        bus.wr_seg   = wr_seg_q;
        bus.wr_addr  = wr_addr_q;
        bus.wr_data  = wr_data_q;
        bus.done     = done_q;
        bus.err      = err_q;
        bus.err_code = err_code_q;
    end

endmodule
